// File: rtl/ahb_rand_stim_gen_pkg.sv
// Shared types and helpers for the AHB random stimulus generator:
// FSM state encoding, LFSR polynomial, mode bit positions and the LFSR step function.
package ahb_stim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GAP   = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DONE  = 2'd3
    } stim_state_e;

    localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;
    localparam int          MODE_INC_BIT = 0;
    localparam int          MODE_SEL_BIT = 1;

    // Galois LFSR, shifting right; the polynomial is folded in when the lsb falls out.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        logic [31:0] r;
        r = {1'b0, s[31:1]};
        if (s[0]) begin
            r = r ^ LFSR_POLY;
        end else begin
            r = r;
        end
        return r;
    endfunction

endpackage

// File: rtl/ahb_rand_stim_gen_if.sv
// AHB-style single-transfer bus between the stimulus generator (master) and the slave.
interface ahb_rand_stim_gen_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              tb_HSEL;
    logic              tb_HWRITE;
    logic [ADDR_W-1:0] tb_HADDR;
    logic [DATA_W-1:0] tb_HWDATA;
    logic              tb_HREADY;
    logic [DATA_W-1:0] tb_HRDATA;

    modport master (
        output tb_HSEL, tb_HWRITE, tb_HADDR, tb_HWDATA,
        input  tb_HREADY, tb_HRDATA
    );

    modport slave (
        input  tb_HSEL, tb_HWRITE, tb_HADDR, tb_HWDATA,
        output tb_HREADY, tb_HRDATA
    );
endinterface

// File: rtl/ahb_rand_stim_gen_lfsr32.sv
// 32-bit Galois LFSR with synchronous reload to its seed and a single-step enable.
module stim_lfsr32
    import ahb_stim_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h0000_0001
) (
    input  logic        clk_i,
    input  logic        load_i,
    input  logic        step_i,
    output logic [31:0] state_o
);
    logic [31:0] state_q;
    logic [31:0] state_d;

    // Reload wins over stepping so a reset always restores the seed.
    always_comb begin
        if (load_i) begin
            state_d = SEED;
        end else if (step_i) begin
            state_d = lfsr_step(state_q);
        end else begin
            state_d = state_q;
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        state_q <= state_d;
    end

    assign state_o = state_q;
endmodule

// File: rtl/ahb_rand_stim_gen.sv
// Pseudo-random AHB single-transfer stimulus generator with stall watchdog.
// Optional STIM_RDSIG_EN adds rd_sig, a rotate-xor signature of read data.
module ahb_rand_stim_gen
    import ahb_stim_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned NUM_TXN = 20,
    parameter int unsigned GAP_CYC = 4,
    parameter int unsigned TIMEOUT = 255,
    parameter logic [31:0] SEED    = 32'hACE1_2024
) (
    input  logic                tb_HCLK,
    input  logic                tb_HRESET,
    input  logic                start,
    input  logic [1:0]          mode,
    ahb_rand_stim_gen_if.master bus,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [15:0]         txn_cnt
`ifdef STIM_RDSIG_EN
    ,
    output logic [DATA_W-1:0]   rd_sig
`endif
);
    localparam logic [7:0]  GAP_LD     = 8'(GAP_CYC);
    localparam logic [15:0] NUM_TXN_W  = 16'(NUM_TXN);
    localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);
    localparam logic [31:0] SEED_AL    = SEED & 32'hFFFF_FFFC;

    stim_state_e       state_q;
    logic [7:0]        gap_q;
    logic [15:0]       wait_q;
    logic [1:0]        mode_q;
    logic              hsel_q;
    logic              hwrite_q;
    logic [ADDR_W-1:0] haddr_q;
    logic [DATA_W-1:0] hwdata_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [15:0]       cnt_q;

    logic [31:0] addr_lfsr_s;
    logic [31:0] data_lfsr_s;
    logic [31:0] inc_addr_s;
    logic        xfer_done_s;
    logic        step_s;
    logic        wd_fire_s;
    logic        unused_lfsr_s;

    stim_lfsr32 #(.SEED(SEED)) u_addr_lfsr (
        .clk_i   (tb_HCLK),
        .load_i  (tb_HRESET),
        .step_i  (step_s),
        .state_o (addr_lfsr_s)
    );

    stim_lfsr32 #(.SEED(~SEED)) u_data_lfsr (
        .clk_i   (tb_HCLK),
        .load_i  (tb_HRESET),
        .step_i  (step_s),
        .state_o (data_lfsr_s)
    );

    // An unselected transfer completes at once; a selected one waits for HREADY.
    assign xfer_done_s = !hsel_q || bus.tb_HREADY;
    assign step_s      = (state_q == ST_ISSUE) && xfer_done_s;
    assign wd_fire_s   = (TIMEOUT != 0) && (state_q == ST_ISSUE) && !xfer_done_s
                         && (wait_q == TIMEOUT_M1);
    assign inc_addr_s  = SEED_AL + {14'd0, cnt_q, 2'b00};
    assign unused_lfsr_s = ^addr_lfsr_s[1:0];

`ifdef STIM_RDSIG_EN
    logic [DATA_W-1:0] rd_q;
    assign rd_sig = rd_q;
`else
    logic unused_rdata_s;
    assign unused_rdata_s = ^bus.tb_HRDATA;
`endif

    // Run sequencer: gap countdown, transfer issue/hold, completion and watchdog.
    always_ff @(posedge tb_HCLK) begin
        if (tb_HRESET) begin
            state_q  <= ST_IDLE;
            gap_q    <= 8'd0;
            wait_q   <= 16'd0;
            mode_q   <= 2'b00;
            hsel_q   <= 1'b0;
            hwrite_q <= 1'b0;
            haddr_q  <= '0;
            hwdata_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= 16'd0;
`ifdef STIM_RDSIG_EN
            rd_q     <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        mode_q  <= mode;
                        cnt_q   <= 16'd0;
                        err_q   <= 1'b0;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        gap_q   <= GAP_LD;
                        state_q <= ST_GAP;
`ifdef STIM_RDSIG_EN
                        rd_q    <= '0;
`endif
                    end
                end
                ST_GAP: begin
                    if (gap_q != 8'd0) begin
                        gap_q <= gap_q - 8'd1;
                    end else begin
                        state_q  <= ST_ISSUE;
                        wait_q   <= 16'd0;
                        hsel_q   <= addr_lfsr_s[31] | mode_q[MODE_SEL_BIT];
                        hwrite_q <= data_lfsr_s[0];
                        hwdata_q <= data_lfsr_s[DATA_W-1:0];
                        haddr_q  <= mode_q[MODE_INC_BIT] ? inc_addr_s[ADDR_W-1:0]
                                                         : {addr_lfsr_s[ADDR_W-1:2], 2'b00};
                    end
                end
                ST_ISSUE: begin
                    if (xfer_done_s) begin
                        cnt_q    <= cnt_q + 16'd1;
                        hsel_q   <= 1'b0;
                        hwrite_q <= 1'b0;
                        haddr_q  <= '0;
                        hwdata_q <= '0;
`ifdef STIM_RDSIG_EN
                        if (hsel_q && !hwrite_q) begin
                            rd_q <= ((rd_q << 1) | (rd_q >> (DATA_W - 1))) ^ bus.tb_HRDATA;
                        end
`endif
                        if (cnt_q + 16'd1 == NUM_TXN_W) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_GAP;
                            gap_q   <= GAP_LD;
                        end
                    end else if (wd_fire_s) begin
                        err_q    <= 1'b1;
                        hsel_q   <= 1'b0;
                        hwrite_q <= 1'b0;
                        haddr_q  <= '0;
                        hwdata_q <= '0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= ST_DONE;
                    end else begin
                        wait_q <= wait_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tb_HSEL   = hsel_q;
    assign bus.tb_HWRITE = hwrite_q;
    assign bus.tb_HADDR  = haddr_q;
    assign bus.tb_HWDATA = hwdata_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign txn_cnt       = cnt_q;
endmodule

// File: tb/tb_ahb_rand_stim_gen.sv
// Scoreboard bench for ahb_rand_stim_gen: expected transfers are predicted from an
// independent LFSR model at start time and compared as each transfer appears.
module tb_ahb_rand_stim_gen;
    localparam int          GAP  = 4;
    localparam int          NTX  = 20;
    localparam logic [31:0] SEED = 32'hACE1_2024;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, start1;
    logic [1:0]  mode0, mode1;
    logic        busy0, done0, err0, busy1, done1, err1;
    logic [15:0] cnt0, cnt1;
`ifdef STIM_RDSIG_EN
    logic [31:0] rd_sig0, rd_sig1;
`endif

    always #5 clk = ~clk;

    ahb_rand_stim_gen_if #(.DATA_W(32), .ADDR_W(32)) bus0 ();
    ahb_rand_stim_gen_if #(.DATA_W(32), .ADDR_W(32)) bus1 ();

    ahb_rand_stim_gen #(.NUM_TXN(NTX), .GAP_CYC(GAP), .TIMEOUT(255), .SEED(SEED)) dut0 (
        .tb_HCLK(clk), .tb_HRESET(rst), .start(start0), .mode(mode0), .bus(bus0),
        .busy(busy0), .done(done0), .err(err0), .txn_cnt(cnt0)
`ifdef STIM_RDSIG_EN
        , .rd_sig(rd_sig0)
`endif
    );

    ahb_rand_stim_gen #(.NUM_TXN(3), .GAP_CYC(GAP), .TIMEOUT(8), .SEED(SEED)) dut1 (
        .tb_HCLK(clk), .tb_HRESET(rst), .start(start1), .mode(mode1), .bus(bus1),
        .busy(busy1), .done(done1), .err(err1), .txn_cnt(cnt1)
`ifdef STIM_RDSIG_EN
        , .rd_sig(rd_sig1)
`endif
    );

    typedef struct {
        logic        sel;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;

    xfer_t       sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_addr, m_data, m_rd;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        logic [31:0] r;
        r = s >> 1;
        if (s[0]) r = r ^ 32'h8020_0003;
        return r;
    endfunction

    task automatic model_reset();
        m_addr = SEED;
        m_data = ~SEED;
        m_rd   = 32'd0;
    endtask

    task automatic check_idle0(input string tag);
        check_val({tag, "_hsel"}, bus0.tb_HSEL, 1'b0);
        check_val({tag, "_hwrite"}, bus0.tb_HWRITE, 1'b0);
        check_val({tag, "_haddr"}, bus0.tb_HADDR, 32'd0);
        check_val({tag, "_hwdata"}, bus0.tb_HWDATA, 32'd0);
        check_val({tag, "_busy"}, busy0, 1'b0);
        check_val({tag, "_done"}, done0, 1'b0);
        check_val({tag, "_err"}, err0, 1'b0);
        check_val({tag, "_cnt"}, cnt0, 16'd0);
    endtask

    // One full run on dut0; optional stall of stall_len edges on transfer stall_idx.
    task automatic run0(input logic [1:0] md, input int stall_idx, input int stall_len,
                        input bit chk_const);
        logic [31:0] a, d;
        xfer_t       x;
        a = m_addr;
        d = m_data;
        for (int k = 0; k < NTX; k++) begin
            x.sel  = a[31] | md[1];
            x.wr   = d[0];
            x.data = d;
            x.addr = md[0] ? ((SEED & 32'hFFFF_FFFC) + 32'(4 * k)) : {a[31:2], 2'b00};
            sb_q.push_back(x);
            a = lfsr_next(a);
            d = lfsr_next(d);
        end
        m_rd = 32'd0;
        @(negedge clk);
        mode0  = md;
        start0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        for (int k = 0; k < NTX; k++) begin
            if (k == 0) begin
                repeat (GAP) @(posedge clk);
                @(negedge clk);
                check_val("pre_issue_hsel", bus0.tb_HSEL, 1'b0);
                check_val("gap_busy", busy0, 1'b1);
                @(posedge clk);
                @(negedge clk);
            end else begin
                repeat (GAP + 2) @(posedge clk);
                @(negedge clk);
            end
            x = sb_q.pop_front();
            check_val("hsel", bus0.tb_HSEL, x.sel);
            check_val("hwrite", bus0.tb_HWRITE, x.wr);
            check_val("haddr", bus0.tb_HADDR, x.addr);
            check_val("hwdata", bus0.tb_HWDATA, x.data);
            check_val("txn_cnt_mid", cnt0, 16'(k));
            if (chk_const && k == 0) begin
                check_val("first_haddr", bus0.tb_HADDR, 32'hACE1_2024);
                check_val("first_hwdata", bus0.tb_HWDATA, 32'h531E_DFDB);
            end
            if (k == stall_idx && x.sel) begin
                bus0.tb_HREADY = 1'b0;
                for (int j = 0; j < stall_len; j++) begin
                    @(posedge clk);
                    @(negedge clk);
                    check_val("stall_hsel", bus0.tb_HSEL, x.sel);
                    check_val("stall_haddr", bus0.tb_HADDR, x.addr);
                    check_val("stall_hwdata", bus0.tb_HWDATA, x.data);
                    check_val("stall_cnt", cnt0, 16'(k));
                end
                bus0.tb_HREADY = 1'b1;
            end
            if (x.sel && !x.wr) m_rd = {m_rd[30:0], m_rd[31]} ^ 32'h1;
            m_addr = lfsr_next(m_addr);
            m_data = lfsr_next(m_data);
        end
        @(posedge clk);
        @(negedge clk);
        check_val("end_done", done0, 1'b1);
        check_val("end_busy", busy0, 1'b0);
        check_val("end_cnt", cnt0, 16'(NTX));
        check_val("end_hsel", bus0.tb_HSEL, 1'b0);
        check_val("sb_empty", 32'(sb_q.size()), 32'd0);
`ifdef STIM_RDSIG_EN
        check_val("rd_sig", rd_sig0, m_rd);
`endif
    endtask

    initial begin
        rst = 1'b1;
        start0 = 1'b0; start1 = 1'b0;
        mode0 = 2'b00; mode1 = 2'b00;
        bus0.tb_HREADY = 1'b1; bus0.tb_HRDATA = 32'h1;
        bus1.tb_HREADY = 1'b0; bus1.tb_HRDATA = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle0("rst");
        rst = 1'b0;
        model_reset();

        run0(2'b00, -1, 0, 1'b1);
        run0(2'b11, 2, 3, 1'b0);

        // Reset in the middle of a selected transfer, then replay the first run.
        @(negedge clk);
        mode0  = 2'b10;
        start0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        bus0.tb_HREADY = 1'b0;
        repeat (GAP + 1) @(posedge clk);
        @(negedge clk);
        check_val("mid_issue_hsel", bus0.tb_HSEL, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus0.tb_HREADY = 1'b1;
        check_idle0("midrst");
        model_reset();
        run0(2'b00, -1, 0, 1'b1);

        // Watchdog: dut1 has TIMEOUT=8 and its slave never becomes ready.
        @(negedge clk);
        mode1  = 2'b10;
        start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        repeat (GAP + 1) @(posedge clk);
        @(negedge clk);
        check_val("wd_issue_hsel", bus1.tb_HSEL, 1'b1);
        check_val("wd_issue_haddr", bus1.tb_HADDR, 32'hACE1_2024);
        repeat (7) @(posedge clk);
        @(negedge clk);
        check_val("wd_early_err", err1, 1'b0);
        check_val("wd_early_hsel", bus1.tb_HSEL, 1'b1);
        check_val("wd_early_busy", busy1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check_val("wd_err", err1, 1'b1);
        check_val("wd_done", done1, 1'b1);
        check_val("wd_busy", busy1, 1'b0);
        check_val("wd_cnt", cnt1, 16'd0);
        check_val("wd_hsel", bus1.tb_HSEL, 1'b0);
        check_val("wd_haddr", bus1.tb_HADDR, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
